// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, owner and access-width encodings for mem_arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
    localparam logic OWN_D = 1'b0;
    localparam logic OWN_I = 1'b1;
    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;
    // the reserved width code behaves as a full word access
    function automatic logic [1:0] norm_width(input logic [1:0] w);
        return (w == W_BYTE || w == W_HALF) ? w : W_WORD;
    endfunction
endpackage

// File: rtl/arb_streak_ctr.sv
// arb_streak_ctr: counts consecutive D grants taken while I waits; force_i
// flags that the next contested grant must go to I.
module arb_streak_ctr import mem_arb_pkg::*; #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic grant,
    input  logic owner,
    input  logic pending,
    output logic force_i
);
    localparam logic [3:0] MAX = 4'(MAX_D_STREAK);
    logic [3:0] streak;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) streak <= '0;
        else if (grant) streak <= (owner == OWN_D && pending) ? ((streak == MAX) ? MAX : streak + 4'd1) : '0;
    end
    assign force_i = streak == MAX;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a D (load/store) and an I (fetch)
// requester, one transaction at a time, with D priority and an I starvation guard.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_req,
    input  logic        i_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] i_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_width,
    output logic        d_gnt,
    output logic        i_gnt,
    output logic        d_rvalid,
    output logic        i_rvalid,
    output logic [31:0] rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_width,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    state_t state;
    logic owner;
    logic [7:0] timer;
    logic force_i, idle, sel_i, sel_d;
    // grants are gated by rst_n so nothing is granted while reset is held
    assign idle = rst_n && state == IDLE;
    assign sel_i = idle && i_req && (!d_req || force_i);
    assign sel_d = idle && d_req && !sel_i;
    assign d_gnt = sel_d;
    assign i_gnt = sel_i;
    assign mem_req = state == ISSUE;
    assign d_rvalid = state == RESP && owner == OWN_D;
    assign i_rvalid = state == RESP && owner == OWN_I;

    arb_streak_ctr #(.MAX_D_STREAK(MAX_D_STREAK)) u_streak (
        .clk(clk),
        .rst_n(rst_n),
        .grant(sel_d || sel_i),
        .owner(sel_i),
        .pending(i_req),
        .force_i(force_i)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= OWN_D;
            timer <= '0;
            mem_addr <= '0;
            mem_we <= 1'b0;
            mem_wdata <= '0;
            mem_width <= '0;
            rdata <= '0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (sel_d || sel_i) begin
                    owner <= sel_i;
                    mem_addr <= sel_i ? i_addr : d_addr;
                    mem_we <= sel_d && d_we;
                    mem_wdata <= sel_i ? 32'd0 : d_wdata;
                    mem_width <= sel_i ? W_WORD : norm_width(d_width);
                    state <= ISSUE;
                end
                ISSUE: if (mem_ready) begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: if (mem_rvalid) begin
                    rdata <= mem_rdata;
                    resp_err <= 1'b0;
                    state <= RESP;
                end else if (timer == 8'(TIMEOUT - 1)) begin
                    rdata <= '0;
                    resp_err <= 1'b1;
                    state <= RESP;
                end else begin
                    timer <= timer + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a response scoreboard and a reactive
// memory model; a monitor pops expected responses whenever an rvalid appears.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic d_req = 1'b0, i_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, i_addr = '0, d_wdata = '0;
    logic [1:0] d_width = 2'd2;
    logic d_gnt, i_gnt, d_rvalid, i_rvalid, resp_err;
    logic [31:0] rdata;
    logic mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0] mem_width;
    logic mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    typedef struct {logic port_i; logic [31:0] data; logic err;} resp_t;
    resp_t q[$];
    int checks = 0;
    int failures = 0;
    int ready_dly = 0;
    bit withhold = 0;
    bit stray = 0;

    mem_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_req(d_req), .i_req(i_req), .d_addr(d_addr), .i_addr(i_addr),
        .d_we(d_we), .d_wdata(d_wdata), .d_width(d_width),
        .d_gnt(d_gnt), .i_gnt(i_gnt), .d_rvalid(d_rvalid), .i_rvalid(i_rvalid),
        .rdata(rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_width(mem_width),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hCAFE0000);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic port_i, input logic [31:0] data, input logic err);
        resp_t e;
        e.port_i = port_i;
        e.data = data;
        e.err = err;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && q.size() != 0; n++) next();
        check("drain_queue_empty", q.size(), 0);
    endtask

    // memory: accepts after ready_dly waiting cycles, answers on the first WAIT cycle
    initial begin
        int rcnt;
        bit pending;
        logic [31:0] resp_data;
        rcnt = 0;
        pending = 0;
        resp_data = '0;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                pending = 0;
                rcnt = 0;
            end else if (mem_req) begin
                if (rcnt == ready_dly) begin
                    mem_ready = 1'b1;
                    rcnt = 0;
                    pending = !withhold;
                    resp_data = mem_model(mem_addr);
                end else rcnt++;
            end else if (pending) begin
                mem_rvalid = 1'b1;
                mem_rdata = resp_data;
                pending = 0;
            end
            if (stray) begin
                mem_rvalid = 1'b1;
                mem_rdata = 32'h57575757;
                stray = 0;
            end
        end
    end

    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (d_rvalid || i_rvalid) begin
                check("rvalid_exclusive", {63'd0, d_rvalid & i_rvalid}, 0);
                check("resp_expected", {63'd0, q.size() != 0}, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("resp_port", {63'd0, i_rvalid}, {63'd0, e.port_i});
                    check("resp_rdata", rdata, e.data);
                    check("resp_err", {63'd0, resp_err}, {63'd0, e.err});
                end
            end
        end
    end

    initial begin
        logic [9:0] order;
        int cnt;
        #1;
        check("reset_outputs", {d_gnt, i_gnt, d_rvalid, i_rvalid, resp_err, mem_req, mem_we, mem_width},
              0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_rdata", rdata, 0);
        repeat (3) next();
        rst_n = 1'b1;
        next();

        // single D read, zero-wait memory: gnt t, mem_req t+1, rvalid t+3
        d_addr = 32'h100;
        d_we = 1'b0;
        d_width = 2'd2;
        d_req = 1'b1;
        #1;
        check("rd_d_gnt", {d_gnt, i_gnt}, 2'b10);
        push(1'b0, 32'hDEADBEEF, 1'b0);
        next();
        d_req = 1'b0;
        check("rd_mem_req_t1", {mem_req, d_gnt}, 2'b10);
        check("rd_mem_addr", mem_addr, 32'h100);
        next();
        check("rd_mem_req_t2", mem_req, 0);
        next();
        check("rd_d_rvalid_t3", {d_rvalid, i_rvalid}, 2'b10);
        next();

        // D half write with mem_ready delayed 3 cycles
        ready_dly = 3;
        d_addr = 32'h20;
        d_wdata = 32'h12345678;
        d_width = 2'd1;
        d_we = 1'b1;
        d_req = 1'b1;
        #1;
        check("wr_d_gnt", d_gnt, 1);
        push(1'b0, 32'hCAFE0020, 1'b0);
        next();
        d_req = 1'b0;
        d_we = 1'b0;
        cnt = 0;
        for (int n = 0; n < 20 && mem_req; n++) begin
            check("wr_we_width", {mem_we, mem_width}, {1'b1, 2'd1});
            check("wr_addr", mem_addr, 32'h20);
            check("wr_wdata", mem_wdata, 32'h12345678);
            cnt++;
            next();
        end
        check("wr_req_cycles", cnt, 4);
        check("wr_mem_rvalid", mem_rvalid, 1);
        next();
        check("wr_d_rvalid_next", d_rvalid, 1);
        ready_dly = 0;
        next();

        // both held high: D,D,D,D,I,D,D,D,D,I
        order = 10'b1000010000;
        d_addr = 32'h300;
        d_width = 2'd2;
        i_addr = 32'h400;
        d_req = 1'b1;
        i_req = 1'b1;
        for (int g = 0; g < 10; g++) begin
            #1;
            for (int n = 0; n < 20 && !(d_gnt || i_gnt); n++) begin
                check("streak_single_gnt", {63'd0, d_gnt & i_gnt}, 0);
                next();
            end
            check("streak_gnt_seen", {63'd0, d_gnt | i_gnt}, 1);
            check("streak_single_gnt", {63'd0, d_gnt & i_gnt}, 0);
            check("streak_order", {63'd0, i_gnt}, {63'd0, order[g]});
            push(order[g], order[g] ? 32'hCAFE0400 : 32'hCAFE0300, 1'b0);
            next();
        end
        d_req = 1'b0;
        i_req = 1'b0;
        drain();

        // timeout: rvalid 64 cycles after entering WAIT (65 samples after the ISSUE sample)
        withhold = 1;
        d_addr = 32'h500;
        d_req = 1'b1;
        #1;
        check("to_d_gnt", d_gnt, 1);
        push(1'b0, 32'h0, 1'b1);
        next();
        d_req = 1'b0;
        check("to_issue", {mem_req, mem_ready}, 2'b11);
        cnt = 0;
        for (int n = 0; n < 100 && !(d_rvalid || i_rvalid); n++) begin
            next();
            cnt++;
        end
        check("to_latency", cnt, 65);
        stray = 1;
        repeat (5) next();
        withhold = 0;
        drain();

        // reset asserted in WAIT
        withhold = 1;
        d_addr = 32'h600;
        d_req = 1'b1;
        #1;
        check("rst_d_gnt", d_gnt, 1);
        next();
        d_req = 1'b0;
        next();
        next();
        check("rst_in_wait", mem_req, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {mem_req, d_rvalid, i_rvalid, resp_err, mem_we}, 0);
        check("rst_async_addr", mem_addr, 0);
        next();
        rst_n = 1'b1;
        withhold = 0;
        stray = 1;
        next();
        next();
        check("rst_stray_ignored", {mem_req, d_rvalid, i_rvalid}, 0);

        // I fetch after reset
        i_addr = 32'h40;
        i_req = 1'b1;
        #1;
        check("if_gnt", {d_gnt, i_gnt}, 2'b01);
        push(1'b1, 32'hCAFE0040, 1'b0);
        next();
        i_req = 1'b0;
        check("if_mem_ctl", {mem_req, mem_we, mem_width}, {1'b1, 1'b0, 2'd2});
        check("if_mem_addr", mem_addr, 32'h40);
        check("if_mem_wdata", mem_wdata, 0);
        next();
        next();
        check("if_rvalid", {d_rvalid, i_rvalid}, 2'b01);
        drain();
        repeat (3) next();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
